// File: rtl/region_frame_buffer_pkg.sv
// rtl/region_frame_buffer_pkg.sv - shared types and widths for the region frame buffer
//
// Holds the render FSM encoding, the scan coordinate widths and the width of
// the renderer pixel word. Imported by the interface and the top module.

package rfb_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int PIXEL_W  = 24;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } rfb_state_e;

endpackage

// File: rtl/region_frame_buffer_if.sv
// rtl/region_frame_buffer_if.sv - renderer-side coordinate and pixel streams
//
// coord_*  : scan coordinate stream, frame buffer -> renderer
// pixel_*  : rendered pixel stream, renderer -> frame buffer
// master   : frame buffer side (issues coordinates, accepts pixels)
// slave    : renderer side

interface region_frame_buffer_if;

    logic [rfb_pkg::HCOUNT_W-1:0] coord_hcount_tdata;
    logic [rfb_pkg::VCOUNT_W-1:0] coord_vcount_tdata;
    logic                         coord_tvalid;
    logic                         coord_tready;

    logic [rfb_pkg::PIXEL_W-1:0]  pixel_tdata;
    logic [rfb_pkg::HCOUNT_W-1:0] pixel_hcount;
    logic [rfb_pkg::VCOUNT_W-1:0] pixel_vcount;
    logic                         pixel_tvalid;
    logic                         pixel_tready;

    modport master (
        output coord_hcount_tdata, coord_vcount_tdata, coord_tvalid,
        input  coord_tready,
        input  pixel_tdata, pixel_hcount, pixel_vcount, pixel_tvalid,
        output pixel_tready
    );

    modport slave (
        input  coord_hcount_tdata, coord_vcount_tdata, coord_tvalid,
        output coord_tready,
        output pixel_tdata, pixel_hcount, pixel_vcount, pixel_tvalid,
        input  pixel_tready
    );

endinterface

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv - block RAM, write port A, read port B
//
// Port A: clka, ena, wea, addra, dina           (write)
// Port B: clkb, enb, addrb, rstb, regceb, doutb (read)
// HIGH_PERFORMANCE adds an output register on port B (2-cycle read latency);
// LOW_LATENCY returns the RAM latch directly (1 cycle). Contents are not reset.

module xilinx_true_dual_port_read_first_2_clock_ram #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic                         clka,
    input  logic                         clkb,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         wea,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         rstb,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_b;

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            ram_b <= mem[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign doutb = ram_b;
        end else begin : g_high_performance
            always_ff @(posedge clkb) begin
                if (rstb) begin
                    doutb <= '0;
                end else if (regceb) begin
                    doutb <= ram_b;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/region_frame_buffer.sv
// rtl/region_frame_buffer.sv - double-buffered frame store for a rectangular render region
//
// Scans the region's coordinates out to a renderer, stores the returned pixels
// in the back bank and displays the front bank; banks swap on a display
// new-frame pulse once a full region has been rendered.
// Ports: aclk/aresetn; rend (coord + pixel streams); disp_* display timing in;
// red/green/blue, hs_out, vs_out (2-cycle delayed); frame_done; front_bank.

module region_frame_buffer
    import rfb_pkg::*;
#(
    parameter int START_X  = 390,
    parameter int END_X    = 634,
    parameter int START_Y  = 390,
    parameter int END_Y    = 765,
    parameter int CH_OUT_W = 4,
    parameter logic [3*CH_OUT_W-1:0] BG_COLOR = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    region_frame_buffer_if.master   rend,
    input  logic [HCOUNT_W-1:0]     disp_hcount,
    input  logic [VCOUNT_W-1:0]     disp_vcount,
    input  logic                    disp_hs,
    input  logic                    disp_vs,
    input  logic                    disp_ad,
    input  logic                    disp_nf,
    output logic [CH_OUT_W-1:0]     red,
    output logic [CH_OUT_W-1:0]     green,
    output logic [CH_OUT_W-1:0]     blue,
    output logic                    hs_out,
    output logic                    vs_out,
    output logic                    frame_done,
    output logic                    front_bank
);

    localparam int W      = END_X - START_X;
    localparam int H      = END_Y - START_Y;
    localparam int N      = W * H;
    localparam int ADDR_W = $clog2(2 * N);
    localparam int CNT_W  = $clog2(N + 1);
    localparam int WORD_W = 3 * CH_OUT_W;

    localparam logic [HCOUNT_W-1:0] X_FIRST = HCOUNT_W'(START_X);
    localparam logic [HCOUNT_W-1:0] X_LAST  = HCOUNT_W'(END_X - 1);
    localparam logic [HCOUNT_W-1:0] X_END   = HCOUNT_W'(END_X);
    localparam logic [VCOUNT_W-1:0] Y_FIRST = VCOUNT_W'(START_Y);
    localparam logic [VCOUNT_W-1:0] Y_LAST  = VCOUNT_W'(END_Y - 1);
    localparam logic [VCOUNT_W-1:0] Y_END   = VCOUNT_W'(END_Y);
    localparam logic [CNT_W-1:0]    N_CNT   = CNT_W'(N);
    localparam logic [ADDR_W-1:0]   BANK_SZ = ADDR_W'(N);
    localparam logic [ADDR_W-1:0]   ROW_SZ  = ADDR_W'(W);

    rfb_state_e          state, next_state;
    logic [HCOUNT_W-1:0] coord_h;
    logic [VCOUNT_W-1:0] coord_v;
    logic [CNT_W-1:0]    pix_count;
    logic                run;
    logic                front_valid;

    logic                coord_fire;
    logic                coord_last;
    logic                swap;

    logic                pix_in_region;
    logic                pix_we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;

    logic                disp_in_region;
    logic [ADDR_W-1:0]   front_base;
    logic [ADDR_W-1:0]   rd_addr;
    logic [WORD_W-1:0]   ram_q;

    logic [1:0]          ad_d, in_d, hs_d, vs_d;
    logic [WORD_W-1:0]   out_word;

    assign coord_fire = rend.coord_tvalid && rend.coord_tready;
    assign coord_last = (coord_h == X_LAST) && (coord_v == Y_LAST);
    assign swap       = (state == DONE) && disp_nf;

    // Render FSM: state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= SCAN;
        end else begin
            state <= next_state;
        end
    end

    // Render FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            SCAN:    if (coord_fire && coord_last) next_state = DRAIN;
            DRAIN:   if (pix_count == N_CNT)       next_state = DONE;
            DONE:    if (disp_nf)                  next_state = SCAN;
            default:                               next_state = SCAN;
        endcase
    end

    // Render FSM: outputs; run keeps the stream quiet while in reset
    always_comb begin
        rend.coord_tvalid = run && (state == SCAN);
    end

    assign rend.coord_hcount_tdata = coord_h;
    assign rend.coord_vcount_tdata = coord_v;
    assign rend.pixel_tready       = run;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run         <= 1'b0;
            coord_h     <= X_FIRST;
            coord_v     <= Y_FIRST;
            pix_count   <= '0;
            front_bank  <= 1'b0;
            front_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            run        <= 1'b1;
            frame_done <= swap;
            if (swap) begin
                front_bank  <= ~front_bank;
                front_valid <= 1'b1;
                coord_h     <= X_FIRST;
                coord_v     <= Y_FIRST;
                pix_count   <= '0;
            end else begin
                // The final coordinate is held; the FSM leaves SCAN on that beat.
                if (coord_fire && !coord_last) begin
                    if (coord_h == X_LAST) begin
                        coord_h <= X_FIRST;
                        coord_v <= coord_v + 1'b1;
                    end else begin
                        coord_h <= coord_h + 1'b1;
                    end
                end
                if (pix_we && (pix_count != N_CNT)) begin
                    pix_count <= pix_count + 1'b1;
                end
            end
        end
    end

    // Pixel write path into the back bank
    assign pix_in_region = (rend.pixel_hcount >= X_FIRST) && (rend.pixel_hcount < X_END) &&
                           (rend.pixel_vcount >= Y_FIRST) && (rend.pixel_vcount < Y_END);
    assign pix_we  = run && rend.pixel_tvalid && pix_in_region;
    assign wr_addr = ADDR_W'(rend.pixel_hcount - X_FIRST)
                   + ADDR_W'(rend.pixel_vcount - Y_FIRST) * ROW_SZ
                   + (front_bank ? '0 : BANK_SZ);
    assign wr_data = {rend.pixel_tdata[23 -: CH_OUT_W],
                      rend.pixel_tdata[15 -: CH_OUT_W],
                      rend.pixel_tdata[7  -: CH_OUT_W]};

    // Display read path from the front bank; outside the region the address
    // parks at the bank base so it can never leave the front bank.
    assign disp_in_region = (disp_hcount >= X_FIRST) && (disp_hcount < X_END) &&
                            (disp_vcount >= Y_FIRST) && (disp_vcount < Y_END);
    assign front_base = front_bank ? BANK_SZ : '0;
    assign rd_addr    = disp_in_region
                      ? front_base + ADDR_W'(disp_hcount - X_FIRST)
                                   + ADDR_W'(disp_vcount - Y_FIRST) * ROW_SZ
                      : front_base;

    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH       (WORD_W),
        .RAM_DEPTH       (2 * N),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_ram (
        .clka   (aclk),
        .clkb   (aclk),
        .ena    (1'b1),
        .enb    (1'b1),
        .wea    (pix_we),
        .addra  (wr_addr),
        .addrb  (rd_addr),
        .dina   (wr_data),
        .rstb   (1'b0),
        .regceb (1'b1),
        .doutb  (ram_q)
    );

    // Sync and qualifier flags follow the RAM's two register stages
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ad_d <= '0;
            in_d <= '0;
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            ad_d <= {ad_d[0], disp_ad};
            in_d <= {in_d[0], disp_in_region};
            hs_d <= {hs_d[0], disp_hs};
            vs_d <= {vs_d[0], disp_vs};
        end
    end

    always_comb begin
        out_word = ram_q;
        if (!ad_d[1]) begin
            out_word = '0;
        end else if (!in_d[1] || !front_valid) begin
            out_word = BG_COLOR;
        end
    end

    assign red    = out_word[3*CH_OUT_W-1 -: CH_OUT_W];
    assign green  = out_word[2*CH_OUT_W-1 -: CH_OUT_W];
    assign blue   = out_word[CH_OUT_W-1   -: CH_OUT_W];
    assign hs_out = hs_d[1];
    assign vs_out = vs_d[1];

endmodule

// File: tb/tb_region_frame_buffer.sv
// tb/tb_region_frame_buffer.sv - scoreboard bench for region_frame_buffer

module tb_region_frame_buffer;
    import rfb_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    region_frame_buffer_if rif ();

    logic [10:0] disp_hcount;
    logic [9:0]  disp_vcount;
    logic        disp_hs, disp_vs, disp_ad, disp_nf;
    logic [3:0]  red, green, blue;
    logic        hs_out, vs_out, frame_done, front_bank;

    region_frame_buffer #(
        .START_X (10), .END_X (14), .START_Y (5), .END_Y (8),
        .CH_OUT_W (4), .BG_COLOR (12'h00F)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .rend        (rif.master),
        .disp_hcount (disp_hcount),
        .disp_vcount (disp_vcount),
        .disp_hs     (disp_hs),
        .disp_vs     (disp_vs),
        .disp_ad     (disp_ad),
        .disp_nf     (disp_nf),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .frame_done  (frame_done),
        .front_bank  (front_bank)
    );

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct { int h; int v; } coord_t;
    typedef struct { int due; logic [11:0] col; logic hs; logic vs; } disp_t;
    coord_t coord_q[$];
    disp_t  disp_q[$];
    coord_t ce;
    disp_t  de;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bad(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: accepted coordinate beats and due display samples
    always @(negedge aclk) begin
        if (aresetn && rif.coord_tvalid && rif.coord_tready) begin
            if (coord_q.size() == 0) begin
                bad("coord_unexpected_beat");
            end else begin
                ce = coord_q.pop_front();
                chk("coord_h", 32'(rif.coord_hcount_tdata), 32'(ce.h));
                chk("coord_v", 32'(rif.coord_vcount_tdata), 32'(ce.v));
            end
        end
        while (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
            de = disp_q.pop_front();
            if (de.due < cyc) begin
                bad("disp_sample_missed");
            end else begin
                chk("disp_colour", 32'({red, green, blue}), 32'(de.col));
                chk("disp_sync", 32'({hs_out, vs_out}), 32'({de.hs, de.vs}));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic push_frame_coords();
        for (int v = 5; v < 8; v++)
            for (int h = 10; h < 14; h++)
                coord_q.push_back('{h: h, v: v});
    endtask

    task automatic wait_scan(input bit bp);
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (bp) rif.coord_tready = (i % 2 == 0);
            tick(1);
            if (!rif.coord_tvalid) done = 1'b1;
        end
        chk("scan_reaches_drain", 32'(done), 32'd1);
        chk("scan_all_coords", 32'(coord_q.size()), 32'd0);
    endtask

    task automatic send_pix(input int h, input int v, input logic [23:0] d);
        rif.pixel_hcount = 11'(h);
        rif.pixel_vcount = 10'(v);
        rif.pixel_tdata  = d;
        rif.pixel_tvalid = 1'b1;
        tick(1);
        rif.pixel_tvalid = 1'b0;
    endtask

    task automatic drive_disp(input int h, input int v, input logic ad, input logic hs,
                              input logic vs, input logic [11:0] exp);
        disp_hcount = 11'(h);
        disp_vcount = 10'(v);
        disp_ad = ad;
        disp_hs = hs;
        disp_vs = vs;
        disp_q.push_back('{due: cyc + 2, col: exp, hs: hs, vs: vs});
        tick(1);
    endtask

    task automatic disp_idle();
        disp_hcount = '0;
        disp_vcount = '0;
        disp_ad = 1'b0;
        disp_hs = 1'b0;
        disp_vs = 1'b0;
    endtask

    task automatic pulse_nf();
        disp_nf = 1'b1;
        tick(1);
        disp_nf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rif.coord_tready = 1'b0;
        rif.pixel_tvalid = 1'b0;
        rif.pixel_tdata  = '0;
        rif.pixel_hcount = '0;
        rif.pixel_vcount = '0;
        disp_nf = 1'b0;
        // Active display inputs during reset: outputs must still be held at 0
        disp_hcount = 11'd11; disp_vcount = 10'd6;
        disp_ad = 1'b1; disp_hs = 1'b1; disp_vs = 1'b1;
        tick(3);
        chk("rst_coord_tvalid", 32'(rif.coord_tvalid), 0);
        chk("rst_pixel_tready", 32'(rif.pixel_tready), 0);
        chk("rst_coord_xy", 32'({rif.coord_hcount_tdata, rif.coord_vcount_tdata}), 32'({11'd10, 10'd5}));
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_front_bank", 32'(front_bank), 0);
        chk("rst_outputs", 32'({red, green, blue, hs_out, vs_out}), 0);

        // Frame 1: free-running scan
        disp_idle();
        push_frame_coords();
        rif.coord_tready = 1'b1;
        aresetn = 1'b1;
        tick(1);
        chk("pixel_tready_after_rst", 32'(rif.pixel_tready), 1);
        wait_scan(1'b0);
        rif.coord_tready = 1'b0;

        drive_disp(10, 5, 1'b1, 1'b0, 1'b0, 12'h00F);
        disp_idle();
        tick(3);

        for (int i = 0; i < 11; i++) send_pix(10 + i % 4, 5 + i / 4, 24'hA0B0C0);
        send_pix(20, 5, 24'hA0B0C0);
        tick(1);
        pulse_nf();
        chk("early_nf_no_done", 32'(frame_done), 0);
        chk("early_nf_no_swap", 32'(front_bank), 0);
        tick(1);
        chk("early_nf_no_done2", 32'(frame_done), 0);
        send_pix(13, 7, 24'hA0B0C0);
        tick(2);
        pulse_nf();
        chk("swap1_frame_done", 32'(frame_done), 1);
        chk("swap1_front_bank", 32'(front_bank), 1);
        tick(1);
        chk("swap1_done_one_cycle", 32'(frame_done), 0);

        for (int i = 0; i < 12; i++)
            drive_disp(10 + i % 4, 5 + i / 4, 1'b1, 1'(i % 2), 1'(i / 2 % 2), 12'hABC);
        drive_disp(0, 0, 1'b1, 1'b1, 1'b0, 12'h00F);
        drive_disp(0, 0, 1'b0, 1'b0, 1'b1, 12'h000);
        drive_disp(11, 6, 1'b0, 1'b0, 1'b0, 12'h000);
        drive_disp(14, 5, 1'b1, 1'b0, 1'b0, 12'h00F);
        drive_disp(9, 5, 1'b1, 1'b0, 1'b0, 12'h00F);
        drive_disp(10, 8, 1'b1, 1'b0, 1'b0, 12'h00F);
        drive_disp(13, 4, 1'b1, 1'b0, 1'b0, 12'h00F);
        disp_idle();
        tick(3);

        // Frame 2: backpressured scan, distinct data into bank 0
        push_frame_coords();
        wait_scan(1'b1);
        rif.coord_tready = 1'b0;
        for (int i = 11; i >= 0; i--) send_pix(10 + i % 4, 5 + i / 4, 24'h123456);
        tick(2);
        pulse_nf();
        chk("swap2_frame_done", 32'(frame_done), 1);
        chk("swap2_front_bank", 32'(front_bank), 0);
        drive_disp(10, 5, 1'b1, 1'b0, 1'b0, 12'h135);
        drive_disp(13, 7, 1'b1, 1'b1, 1'b1, 12'h135);
        drive_disp(12, 6, 1'b1, 1'b0, 1'b0, 12'h135);
        disp_idle();
        tick(3);

        // Frame 3: reset mid-DRAIN
        push_frame_coords();
        rif.coord_tready = 1'b1;
        wait_scan(1'b0);
        rif.coord_tready = 1'b0;
        for (int i = 0; i < 5; i++) send_pix(10 + i % 4, 5 + i / 4, 24'hFFFFFF);
        disp_hcount = 11'd10; disp_vcount = 10'd5;
        disp_ad = 1'b1; disp_hs = 1'b1; disp_vs = 1'b1;
        tick(3);
        aresetn = 1'b0;
        #1;
        chk("midrst_coord_tvalid", 32'(rif.coord_tvalid), 0);
        chk("midrst_pixel_tready", 32'(rif.pixel_tready), 0);
        chk("midrst_bank_done", 32'({front_bank, frame_done}), 0);
        chk("midrst_outputs", 32'({red, green, blue, hs_out, vs_out}), 0);
        disp_idle();
        tick(2);
        aresetn = 1'b1;
        tick(2);
        drive_disp(10, 5, 1'b1, 1'b0, 1'b0, 12'h00F);
        drive_disp(12, 6, 1'b1, 1'b0, 1'b0, 12'h00F);
        disp_idle();
        tick(4);
        chk("post_rst_front_bank", 32'(front_bank), 0);
        chk("disp_queue_drained", 32'(disp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/region_frame_buffer.md
REGION_FRAME_BUFFER -- requirements
Module: region_frame_buffer

Interface
REQ-001 Parameter START_X, default 390: first rendered column, inclusive; 11 bits.
REQ-002 Parameter END_X, default 634: last rendered column, exclusive; W = END_X-START_X.
REQ-003 Parameter START_Y, default 390: first rendered row, inclusive; 10 bits.
REQ-004 Parameter END_Y, default 765: last rendered row, exclusive; H = END_Y-START_Y.
REQ-005 Parameter CH_OUT_W, default 4: stored and output bits per colour channel; stored word width is 3*CH_OUT_W.
REQ-006 Parameter BG_COLOR, default 0: {r,g,b} value, 3*CH_OUT_W bits, shown in the active area outside the region.
REQ-007 Ports, in order:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- coord_hcount_tdata  out  11  scan column issued to the renderer.
- coord_vcount_tdata  out  10  scan row issued to the renderer.
- coord_tvalid  out  1  coordinate valid.
- coord_tready  in  1  renderer accepts the coordinate.
- pixel_tdata  in  24  renderer pixel {R8,G8,B8}.
- pixel_hcount  in  11  column of the returned pixel.
- pixel_vcount  in  10  row of the returned pixel.
- pixel_tvalid  in  1  pixel valid.
- pixel_tready  out  1  always 1 after reset.
- disp_hcount  in  11  display column.
- disp_vcount  in  10  display row.
- disp_hs  in  1  display hsync.
- disp_vs  in  1  display vsync.
- disp_ad  in  1  display active draw.
- disp_nf  in  1  display new-frame pulse.
- red, green, blue  out  CH_OUT_W each  display colour.
- hs_out, vs_out  out  1  hsync and vsync delayed to align with colour.
- frame_done  out  1  one-cycle pulse on each buffer swap.
- front_bank  out  1  bank currently displayed.

Function
REQ-008 The block SHALL hold two banks of W*H words; the renderer writes the back bank (!front_bank) while the display reads the front bank.
REQ-009 Render FSM SCAN: coord_tvalid=1; the coordinate advances raster-order only on tvalid&&tready; at (END_X-1, END_Y-1) an accepted beat moves the FSM to DRAIN.
REQ-010 Column wrap: END_X-1 SHALL wrap to START_X with row+1; coord_tvalid and coord_tdata SHALL stay stable while tready=0.
REQ-011 Render FSM DRAIN: coord_tvalid=0; the FSM moves to DONE when the count of accepted in-region pixels reaches W*H.
REQ-012 Render FSM DONE: coord_tvalid=0; on disp_nf=1 the block SHALL toggle front_bank, set front_valid, pulse frame_done, reset the coordinate to (START_X, START_Y) and clear the pixel count, then go to SCAN.
REQ-013 disp_nf in SCAN or DRAIN SHALL be ignored: no swap and no tearing, and the old front bank is shown again.
REQ-014 Write address: (pixel_hcount-START_X) + (pixel_vcount-START_Y)*W + back_bank*W*H. Any pixel_tvalid beat with coordinates outside the region SHALL be dropped and not counted.
REQ-015 Stored word: {R[7:8-CH_OUT_W], G[...], B[...]}, truncated, with no rounding.
REQ-016 Read latency SHALL be exactly 2 cycles from disp_* to red/green/blue.
REQ-017 hs_out, vs_out and the delayed ad and in-region flags SHALL carry the same 2-cycle delay.
REQ-018 Output colour after the delay:
- ad=0: colour 0.
- ad=1 and outside the region: BG_COLOR.
- ad=1, inside the region and front_valid=0: BG_COLOR.
- otherwise: the RAM data.
REQ-019 The read address SHALL be forced to the front-bank base when the display is outside the region, so no out-of-range address is ever issued.
REQ-020 Writing and reading the same address in one cycle is impossible by construction, because the banks differ.
REQ-021 Arithmetic: the address width SHALL be $clog2(2*W*H); the pixel counter SHALL be $clog2(W*H+1) bits and SHALL saturate at W*H.

Reset
REQ-022 On aresetn=0, asynchronously:
- FSM=SCAN, coordinate=(START_X, START_Y), count=0.
- front_bank=0, front_valid=0.
- frame_done=0; all delay stages and colour/sync outputs 0.
- pixel_tready=0 during reset, 1 after.
REQ-023 RAM contents are not reset.
REQ-024 Reset mid-frame SHALL abandon the partial render; the old data is never shown, because front_valid=0.

Structure
REQ-025 Package rfb_pkg SHALL hold the FSM enum (SCAN, DRAIN, DONE), the coordinate widths (11/10) and the input pixel width 24.
REQ-026 Storage SHALL be the existing xilinx_true_dual_port_read_first_2_clock_ram, both ports on aclk, HIGH_PERFORMANCE, depth 2*W*H; this is the only sub-module.

Verification
REQ-027 Test parameters: START_X=10, END_X=14, START_Y=5, END_Y=8 (12 pixels), CH_OUT_W=4, BG_COLOR=12'h00F.
REQ-028 Scenario, scan order: coord_tready=1 constantly -> 12 beats (10,5),(11,5)…(13,7), then coord_tvalid=0 and the FSM is in DRAIN.
REQ-029 Scenario, backpressure: coord_tready toggling 1/0 -> every coordinate is held while tready=0, with no skipped or duplicated coordinate.
REQ-030 Scenario, swap: return 12 pixels 24'hA0B0C0, then pulse disp_nf -> frame_done for 1 cycle, front_bank=1; scanning the region then reads 12'hABC after exactly 2 cycles.
REQ-031 Scenario, early nf: pulse disp_nf after only 11 pixels -> no swap; the 12th pixel then the next disp_nf -> swap.
REQ-032 Scenario, out-of-region and inactive: a pixel at (20,5) is dropped and uncounted; display at (0,0) with ad=1 -> BG 12'h00F; ad=0 -> 0.
REQ-033 Scenario, reset: assert reset mid-DRAIN -> all outputs 0 immediately; after release, in-region display shows BG until the first swap.
